// File: rtl/trena_sequenciador.sv
// trena_sequenciador: control FSM for one ultrasonic distance measurement.
// Starts the trigger pulse, times the echo window against a timeout, latches
// the BCD distance, and then streams it as four ASCII characters
// (hundreds, tens, units, '#') through the serial transmitter.
module trena_sequenciador #(
  parameter int TIMEOUT_CICLOS  = 1250000,
  parameter int LARGURA_TIMEOUT = 21
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mensurar,
  input  logic        echo,
  input  logic        fim_pulso,
  input  logic [11:0] medida,
  input  logic        fim_tx,
  output logic        zera_medida,
  output logic        gera_pulso,
  output logic        conta_medida,
  output logic        partida_tx,
  output logic [6:0]  dado_tx,
  output logic        pronto,
  output logic        erro,
  output logic [3:0]  db_estado
);

  typedef enum logic [3:0] {
    INICIAL      = 4'd0,
    PREPARACAO   = 4'd1,
    ENVIA_PULSO  = 4'd2,
    ESPERA_PULSO = 4'd3,
    ESPERA_ECHO  = 4'd4,
    MEDINDO      = 4'd5,
    ARMAZENA     = 4'd6,
    TRANSMITE    = 4'd7,
    ESPERA_TX    = 4'd8,
    PROXIMO      = 4'd9,
    FINAL        = 4'd10,
    TIMEOUT      = 4'd14
  } estado_t;

  localparam logic [LARGURA_TIMEOUT-1:0] LIMITE = LARGURA_TIMEOUT'(TIMEOUT_CICLOS - 1);

  estado_t                    estado;
  estado_t                    proximo_estado;
  logic                       mensurar_ant;
  logic                       borda;
  logic [LARGURA_TIMEOUT-1:0] contagem;
  logic                       em_janela;
  logic                       estourou;
  logic [1:0]                 indice;
  logic [11:0]                medida_reg;
  logic                       erro_reg;

  // ASCII code of one result character; non-BCD nibbles map to 0x30 + nibble
  // ({3'b011, nibble} is exactly that sum for any 4-bit value).
  function automatic logic [6:0] caractere(input logic [1:0] idx, input logic [11:0] bcd);
    logic [6:0] c;
    case (idx)
      2'd0:    c = {3'b011, bcd[11:8]};
      2'd1:    c = {3'b011, bcd[7:4]};
      2'd2:    c = {3'b011, bcd[3:0]};
      default: c = 7'h23;
    endcase
    return c;
  endfunction

  assign borda     = mensurar & ~mensurar_ant;
  assign em_janela = (estado == ESPERA_PULSO) || (estado == ESPERA_ECHO) || (estado == MEDINDO);
  assign estourou  = em_janela && (contagem == LIMITE);

  // State register and previous sample of mensurar for edge detection
  always_ff @(posedge clock) begin
    if (reset) begin
      estado       <= INICIAL;
      mensurar_ant <= 1'b0;
    end else begin
      estado       <= proximo_estado;
      mensurar_ant <= mensurar;
    end
  end

  // Timeout counter: cleared in preparacao, runs from the trigger through the echo window
  always_ff @(posedge clock) begin
    if (reset || estado == PREPARACAO) begin
      contagem <= '0;
    end else if (estado == ENVIA_PULSO || em_janela) begin
      contagem <= contagem + 1'b1;
    end
  end

  // Result latch and character index
  always_ff @(posedge clock) begin
    if (reset) begin
      medida_reg <= 12'd0;
      indice     <= 2'd0;
    end else if (estado == PREPARACAO) begin
      indice <= 2'd0;
    end else if (estado == ARMAZENA) begin
      medida_reg <= medida;
      indice     <= 2'd0;
    end else if (estado == PROXIMO && indice != 2'd3) begin
      indice <= indice + 2'd1;
    end
  end

  // Error flag: set on entry to timeout so it is visible together with pronto
  always_ff @(posedge clock) begin
    if (reset || estado == PREPARACAO) begin
      erro_reg <= 1'b0;
    end else if (proximo_estado == TIMEOUT) begin
      erro_reg <= 1'b1;
    end
  end

  // Next-state logic; the timeout check overrides fim_pulso/echo transitions
  always_comb begin
    proximo_estado = estado;
    case (estado)
      INICIAL:      if (borda) proximo_estado = PREPARACAO;
      PREPARACAO:   proximo_estado = ENVIA_PULSO;
      ENVIA_PULSO:  proximo_estado = ESPERA_PULSO;
      ESPERA_PULSO: if (estourou) proximo_estado = TIMEOUT;
                    else if (fim_pulso) proximo_estado = ESPERA_ECHO;
      ESPERA_ECHO:  if (estourou) proximo_estado = TIMEOUT;
                    else if (echo) proximo_estado = MEDINDO;
      MEDINDO:      if (estourou) proximo_estado = TIMEOUT;
                    else if (!echo) proximo_estado = ARMAZENA;
      ARMAZENA:     proximo_estado = TRANSMITE;
      TRANSMITE:    proximo_estado = ESPERA_TX;
      ESPERA_TX:    if (fim_tx) proximo_estado = PROXIMO;
      PROXIMO:      proximo_estado = (indice == 2'd3) ? FINAL : TRANSMITE;
      FINAL:        proximo_estado = INICIAL;
      TIMEOUT:      proximo_estado = INICIAL;
      default:      proximo_estado = INICIAL;
    endcase
  end

  // Moore outputs decoded from the registered state
  always_comb begin
    zera_medida  = (estado == PREPARACAO);
    gera_pulso   = (estado == ENVIA_PULSO);
    conta_medida = (estado == MEDINDO) && echo;
    partida_tx   = (estado == TRANSMITE);
    pronto       = (estado == FINAL) || (estado == TIMEOUT);
    dado_tx      = 7'd0;
    if (estado == TRANSMITE || estado == ESPERA_TX) begin
      dado_tx = caractere(indice, medida_reg);
    end
    erro      = erro_reg;
    db_estado = estado;
  end

endmodule

// File: tb/tb_trena_sequenciador.sv
// Directed testbench for trena_sequenciador (TIMEOUT_CICLOS = 100).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_trena_sequenciador;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mensurar = 1'b0;
  logic        echo = 1'b0;
  logic        fim_pulso = 1'b0;
  logic [11:0] medida = 12'h000;
  logic        fim_tx = 1'b0;
  logic        zera_medida, gera_pulso, conta_medida, partida_tx, pronto, erro;
  logic [6:0]  dado_tx;
  logic [3:0]  db_estado;

  int n_checks = 0;
  int n_errors = 0;
  int n_gera = 0;
  int n_partida = 0;

  trena_sequenciador #(.TIMEOUT_CICLOS(100), .LARGURA_TIMEOUT(7)) dut (
    .clock(clock), .reset(reset), .mensurar(mensurar), .echo(echo),
    .fim_pulso(fim_pulso), .medida(medida), .fim_tx(fim_tx),
    .zera_medida(zera_medida), .gera_pulso(gera_pulso), .conta_medida(conta_medida),
    .partida_tx(partida_tx), .dado_tx(dado_tx), .pronto(pronto), .erro(erro),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // Pulse counters for the Moore outputs (value of the cycle just ended)
  always @(posedge clock) begin
    if (gera_pulso) n_gera <= n_gera + 1;
    if (partida_tx) n_partida <= n_partida + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  // Full measurement: mensurar is raised here (and dropped after the first
  // cycle unless hold=1). abort_char >= 0 applies reset in espera_tx of that char.
  task automatic run_medida(input logic [11:0] med, input logic [11:0] med_late,
                            input int n_echo, input int abort_char, input bit hold);
    logic [6:0] esperado [4];
    int conta_hi;
    int partida0;
    esperado[0] = 7'h30 + {3'b000, med[11:8]};
    esperado[1] = 7'h30 + {3'b000, med[7:4]};
    esperado[2] = 7'h30 + {3'b000, med[3:0]};
    esperado[3] = 7'h23;
    medida   = med;
    mensurar = 1'b1;
    step();
    if (!hold) mensurar = 1'b0;
    chk("estado_preparacao", db_estado, 1);
    chk("zera_medida", zera_medida, 1);
    step();
    chk("estado_envia_pulso", db_estado, 2);
    chk("gera_pulso", gera_pulso, 1);
    chk("erro_limpo", erro, 0);
    partida0 = n_partida;
    step();
    chk("estado_espera_pulso", db_estado, 3);
    fim_pulso = 1'b1;
    step();
    fim_pulso = 1'b0;
    chk("estado_espera_echo", db_estado, 4);
    echo = 1'b1;
    conta_hi = 0;
    for (int k = 0; k < n_echo; k++) begin
      step();
      if (conta_medida === 1'b1 && db_estado == 4'd5) conta_hi++;
    end
    chk("conta_medida_ciclos", conta_hi, n_echo);
    echo = 1'b0;
    step();
    chk("estado_armazena", db_estado, 6);
    chk("conta_medida_baixo", conta_medida, 0);
    for (int c = 0; c < 4; c++) begin
      step();
      if (c == 0) medida = med_late;
      chk("estado_transmite", db_estado, 7);
      chk("partida_tx", partida_tx, 1);
      chk("dado_tx_transmite", dado_tx, esperado[c]);
      step();
      chk("estado_espera_tx", db_estado, 8);
      if (c == abort_char) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("reset_saidas", {zera_medida, gera_pulso, conta_medida, partida_tx,
                             dado_tx, pronto, erro, db_estado}, 0);
        step();
        chk("reset_sem_partida", {partida_tx, pronto, db_estado}, 0);
        step();
        chk("reset_sem_partida2", {partida_tx, pronto, db_estado}, 0);
        return;
      end
      for (int w = 0; w < 3; w++) begin
        step();
        chk("dado_tx_estavel", {db_estado, dado_tx}, {4'd8, esperado[c]});
      end
      fim_tx = 1'b1;
      step();
      fim_tx = 1'b0;
      chk("estado_proximo", db_estado, 9);
      chk("dado_tx_zero", dado_tx, 0);
    end
    step();
    chk("estado_final", db_estado, 10);
    chk("pronto_final", pronto, 1);
    chk("erro_final", erro, 0);
    step();
    chk("estado_inicial_apos", db_estado, 0);
    chk("pronto_um_ciclo", pronto, 0);
    chk("partidas", n_partida - partida0, 4);
  endtask

  // Timeout run: echo never rises (prio=0) or falls exactly as the count hits 99 (prio=1)
  task automatic run_timeout(input bit prio);
    int partida0;
    bit ok;
    mensurar = 1'b1;
    step();
    mensurar = 1'b0;
    chk("to_preparacao", db_estado, 1);
    step();
    chk("to_gera_pulso", gera_pulso, 1);
    partida0 = n_partida;
    step();
    chk("to_espera_pulso", db_estado, 3);
    fim_pulso = 1'b1;
    step();
    fim_pulso = 1'b0;
    chk("to_espera_echo", db_estado, 4);
    if (prio) echo = 1'b1;
    ok = 1'b1;
    for (int k = 3; k <= 99; k++) begin
      step();
      if (db_estado !== (prio ? 4'd5 : 4'd4) || pronto !== 1'b0) ok = 1'b0;
      if (k == 99) echo = 1'b0;
    end
    chk("to_janela_estavel", ok, 1);
    step();
    chk("to_estado_14", db_estado, 14);
    chk("to_pronto", pronto, 1);
    chk("to_erro", erro, 1);
    step();
    chk("to_estado_0", db_estado, 0);
    chk("to_erro_mantido", erro, 1);
    chk("to_pronto_um_ciclo", pronto, 0);
    chk("to_sem_partida", n_partida - partida0, 0);
  endtask

  initial begin
    int gera0;
    bit idle;
    reset = 1'b1;
    repeat (3) step();
    chk("reset_estado", db_estado, 0);
    chk("reset_saidas", {zera_medida, gera_pulso, conta_medida, partida_tx,
                         dado_tx, pronto, erro}, 0);
    reset = 1'b0;
    step();
    chk("ocioso", db_estado, 0);

    // Normal run of 0x123 with medida changed to 0x999 after armazena
    gera0 = n_gera;
    run_medida(12'h123, 12'h999, 50, -1, 1'b0);
    step();
    chk("gera_uma_vez", n_gera - gera0, 1);

    // Echo never rises
    run_timeout(1'b0);

    // mensurar held high: one measurement only, erro cleared by it
    gera0 = n_gera;
    run_medida(12'h407, 12'h407, 20, -1, 1'b1);
    idle = 1'b1;
    for (int k = 0; k < 900; k++) begin
      step();
      if (db_estado !== 4'd0) idle = 1'b0;
    end
    chk("mensurar_mantido_ocioso", idle, 1);
    chk("mensurar_mantido_uma", n_gera - gera0, 1);
    mensurar = 1'b0;
    step();
    run_medida(12'h5AF, 12'h000, 5, -1, 1'b0);

    // Reset during espera_tx of char 2, then a fresh run
    run_medida(12'h860, 12'h860, 10, 2, 1'b0);
    run_medida(12'h291, 12'h291, 8, -1, 1'b0);

    // Echo falls on the same cycle the timeout fires
    run_timeout(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
